// File: rtl/rectangle128_pkg.sv
`default_nettype none
// ============================================================================
// rectangle128_pkg
// Shared block-mode encoding, FSM state type and datapath widths.
// Rev 1.0
// ============================================================================
package rectangle128_pkg;

   localparam int BLOCK_W = 64;
   localparam int KEY_W   = 128;

   typedef enum logic [1:0] {
      ECB_ENC = 2'd0,
      ECB_DEC = 2'd1,
      CBC_ENC = 2'd2,
      CBC_DEC = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RDY  = 3'd1,
      BUSY = 3'd2,
      GAP  = 3'd3,
      ERR  = 3'd4
   } state_e;

   function automatic logic is_encrypt(input logic [1:0] mode);
      return (mode == ECB_ENC) || (mode == CBC_ENC);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rectangle128_timeout_cnt.sv
`default_nettype none
// ============================================================================
// rectangle128_timeout_cnt
// Clearable, saturating cycle counter; o_last flags the MAX_COUNT-th enabled cycle.
// Rev 1.0
// ============================================================================
module rectangle128_timeout_cnt #(
   parameter int MAX_COUNT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_last
);

   localparam int              c_cnt_w = (MAX_COUNT < 2) ? 1 : $clog2(MAX_COUNT + 1);
   localparam logic [c_cnt_w-1:0] c_max  = c_cnt_w'(MAX_COUNT);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MAX_COUNT - 1);

   logic [c_cnt_w-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != c_max)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_last = i_en && (r_count >= c_last);

endmodule
`default_nettype wire

// File: rtl/rectangle128_mode_ctrl.sv
`default_nettype none
// ============================================================================
// rectangle128_mode_ctrl
// ECB/CBC block-mode sequencer driving a RECTANGLE-128 cipher core.
// Rev 1.0
// ============================================================================
module rectangle128_mode_ctrl
   import rectangle128_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_start,
   input  logic [1:0]         cfg_mode,
   input  logic [KEY_W-1:0]   cfg_key,
   input  logic [BLOCK_W-1:0] cfg_iv,
   output logic               cfg_ready,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BLOCK_W-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] out_data,
   output logic               core_enable,
   output logic               core_encrypt,
   output logic [BLOCK_W-1:0] core_text_in,
   output logic [BLOCK_W-1:0] core_key0,
   output logic [BLOCK_W-1:0] core_key1,
   input  logic [BLOCK_W-1:0] core_text_out,
   input  logic               core_ready,
   output logic [CNT_W-1:0]   blk_count,
   output logic               err
);

   state_e             r_state;
   state_e             w_next_state;
   mode_e              r_mode;
   logic [KEY_W-1:0]   r_key;
   logic               r_encrypt;
   logic [BLOCK_W-1:0] r_chain;
   logic [BLOCK_W-1:0] r_pending_chain;
   logic [BLOCK_W-1:0] r_text_in;
   logic [BLOCK_W-1:0] r_out_data;
   logic               r_out_valid;
   logic [CNT_W-1:0]   r_blk_count;
   logic               r_err;

   logic               w_busy;
   logic               w_timeout;
   logic               w_cfg_accept;
   logic               w_handshake;
   logic               w_done;
   logic [BLOCK_W-1:0] w_text_sel;
   logic [BLOCK_W-1:0] w_result;

   assign w_busy       = (r_state == BUSY);
   assign w_cfg_accept = cfg_start && cfg_ready;
   assign w_handshake  = in_valid && in_ready;
   assign w_done       = w_busy && core_ready;

   // Mode is stable across any handshake: cfg_start and a handshake never land together.
   assign w_text_sel = (r_mode == CBC_ENC) ? (in_data ^ r_chain) : in_data;
   assign w_result   = (r_mode == CBC_DEC) ? (core_text_out ^ r_chain) : core_text_out;

   rectangle128_timeout_cnt #(
      .MAX_COUNT (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (!w_busy),
      .i_en   (w_busy),
      .o_last (w_timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      cfg_ready    = 1'b0;
      in_ready     = 1'b0;
      core_enable  = 1'b0;
      case (r_state)
         IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_start) w_next_state = RDY;
         end
         RDY: begin
            cfg_ready = 1'b1;
            in_ready  = !r_out_valid && !cfg_start;
            if (!cfg_start && in_valid && in_ready) w_next_state = BUSY;
         end
         BUSY: begin
            core_enable = 1'b1;
            if (core_ready)     w_next_state = GAP;
            else if (w_timeout) w_next_state = ERR;
         end
         GAP: begin
            w_next_state = RDY;
         end
         ERR: begin
            cfg_ready = 1'b1;
            if (cfg_start) w_next_state = RDY;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode          <= ECB_ENC;
         r_key           <= '0;
         r_encrypt       <= 1'b0;
         r_chain         <= '0;
         r_pending_chain <= '0;
         r_text_in       <= '0;
         r_out_data      <= '0;
         r_out_valid     <= 1'b0;
         r_blk_count     <= '0;
         r_err           <= 1'b0;
      end else begin
         if (w_cfg_accept) begin
            r_mode      <= mode_e'(cfg_mode);
            r_key       <= cfg_key;
            r_encrypt   <= is_encrypt(cfg_mode);
            r_chain     <= cfg_iv;
            r_blk_count <= '0;
            r_err       <= 1'b0;
         end
         if (w_handshake) begin
            r_text_in <= w_text_sel;
            if (r_mode == CBC_DEC) r_pending_chain <= in_data;
         end
         // A finished block never meets a live output: in_ready required out_valid low.
         if (w_done) begin
            r_out_data  <= w_result;
            r_out_valid <= 1'b1;
            r_blk_count <= r_blk_count + 1'b1;
            if (r_mode == CBC_ENC)      r_chain <= core_text_out;
            else if (r_mode == CBC_DEC) r_chain <= r_pending_chain;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_busy && (w_next_state == ERR)) r_err <= 1'b1;
      end
   end

   assign core_encrypt = r_encrypt;
   assign core_text_in = r_text_in;
   assign core_key1    = r_key[KEY_W-1:BLOCK_W];
   assign core_key0    = r_key[BLOCK_W-1:0];
   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign blk_count    = r_blk_count;
   assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rectangle128_mode_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rectangle128_mode_ctrl
// Directed + randomized bench with a cycle-level behavioural model and core stub.
// Rev 1.0
// ============================================================================
module tb_rectangle128_mode_ctrl;

   localparam int T   = 255;
   localparam int LAT = 27;   // edges from input handshake to out_valid with the stub core

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_start = 1'b0;
   logic [1:0]   cfg_mode = 2'd0;
   logic [127:0] cfg_key = '0;
   logic [63:0]  cfg_iv = '0;
   logic         cfg_ready;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [63:0]  in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [63:0]  out_data;
   logic         core_enable;
   logic         core_encrypt;
   logic [63:0]  core_text_in;
   logic [63:0]  core_key0;
   logic [63:0]  core_key1;
   logic [63:0]  core_text_out;
   logic         core_ready;
   logic [15:0]  blk_count;
   logic         err;

   int n_chk = 0;
   int n_err = 0;
   int or_mode = 1;          // 0: hold out_ready low, 1: high, 2: random
   bit stub_mute = 1'b0;

   always #5 clk = ~clk;

   rectangle128_mode_ctrl #(
      .TIMEOUT_CYCLES (T),
      .CNT_W          (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_start     (cfg_start),
      .cfg_mode      (cfg_mode),
      .cfg_key       (cfg_key),
      .cfg_iv        (cfg_iv),
      .cfg_ready     (cfg_ready),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .core_enable   (core_enable),
      .core_encrypt  (core_encrypt),
      .core_text_in  (core_text_in),
      .core_key0     (core_key0),
      .core_key1     (core_key1),
      .core_text_out (core_text_out),
      .core_ready    (core_ready),
      .blk_count     (blk_count),
      .err           (err)
   );

   // Core stub: ready 26 cycles after enable rises, result = text ^ key0.
   logic [8:0] stub_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)           stub_cnt <= '0;
      else if (core_enable) stub_cnt <= stub_cnt + 1'b1;
      else                  stub_cnt <= '0;
   end
   assign core_ready    = core_enable && (stub_cnt == 9'd26) && !stub_mute;
   assign core_text_out = core_text_in ^ core_key0;

   always @(negedge clk) begin
      case (or_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   int          cyc = 0;
   bit          m_cfgd, m_err, m_act, m_mute, m_ov;
   logic [1:0]  m_mode;
   logic [63:0] m_key0, m_key1, m_chain, m_text, m_pend, m_od;
   logic [15:0] m_cnt;
   int          m_hs;

   always begin : monitor
      bit busy, e_cfg_ready, e_in_ready;
      @(negedge clk);
      #4;
      cyc++;
      if (!rst_n) begin
         m_cfgd = 0; m_err = 0; m_act = 0; m_ov = 0; m_cnt = '0; m_mode = '0;
         m_key0 = '0; m_key1 = '0; m_chain = '0; m_text = '0; m_od = '0;
         chk("rst core_enable", core_enable, 0);
         chk("rst core_encrypt", core_encrypt, 0);
         chk("rst out_valid", out_valid, 0);
         chk("rst in_ready", in_ready, 0);
         chk("rst err", err, 0);
         chk("rst blk_count", blk_count, 0);
         chk("rst text_in", core_text_in, 0);
         chk("rst key", {core_key1, core_key0}, 0);
         chk("rst out_data", out_data, 0);
      end else begin
         if (m_act && !m_mute && cyc == m_hs + LAT + 1) begin
            m_ov = 1; m_od = m_pend; m_cnt = m_cnt + 16'd1;
         end
         if (m_act && m_mute && cyc == m_hs + T + 1) begin
            m_err = 1; m_act = 0;
         end
         if (m_act && !m_mute && cyc > m_hs + LAT + 1) m_act = 0;

         busy        = m_act && (cyc <= m_hs + (m_mute ? T : LAT));
         e_cfg_ready = !m_act;
         e_in_ready  = m_cfgd && !m_err && !m_act && !m_ov && !cfg_start;

         chk("cfg_ready", cfg_ready, e_cfg_ready);
         chk("in_ready", in_ready, e_in_ready);
         chk("core_enable", core_enable, busy);
         chk("err", err, m_err);
         chk("out_valid", out_valid, m_ov);
         if (m_ov) chk("out_data", out_data, m_od);
         chk("blk_count", blk_count, m_cnt);
         chk("core_encrypt", core_encrypt, m_cfgd ? !m_mode[0] : 1'b0);
         chk("core_keys", {core_key1, core_key0}, {m_key1, m_key0});
         if (m_act) chk("core_text_in", core_text_in, m_text);

         if (cfg_start && e_cfg_ready) begin
            m_cfgd = 1; m_mode = cfg_mode; m_key1 = cfg_key[127:64]; m_key0 = cfg_key[63:0];
            m_chain = cfg_iv; m_cnt = '0; m_err = 0;
         end else if (in_valid && e_in_ready) begin
            case (m_mode)
               2'd2: begin
                  m_text = in_data ^ m_chain;
                  m_pend = m_text ^ m_key0;
                  if (!stub_mute) m_chain = m_pend;
               end
               2'd3: begin
                  m_text = in_data;
                  m_pend = (in_data ^ m_key0) ^ m_chain;
                  if (!stub_mute) m_chain = in_data;
               end
               default: begin
                  m_text = in_data;
                  m_pend = in_data ^ m_key0;
               end
            endcase
            m_act = 1; m_hs = cyc; m_mute = stub_mute;
         end
         if (m_ov && out_ready) m_ov = 0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_cfg(input logic [1:0] mode, input logic [127:0] key, input logic [63:0] iv);
      @(negedge clk);
      cfg_start = 1'b1; cfg_mode = mode; cfg_key = key; cfg_iv = iv;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   // Returns at the negedge just after the handshake edge.
   task automatic send(input logic [63:0] d);
      bit ok = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d;
      for (int i = 0; i < 400 && !ok; i++) begin
         #4;
         if (in_ready) ok = 1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!ok) chk("handshake bound", 0, 1);
   endtask

   task automatic wait_out(output logic [63:0] d, output int lat);
      bit ok = 0;
      d = '0; lat = -1;
      for (int k = 1; k <= 400; k++) begin
         #4;
         if (out_valid) begin
            ok = 1; lat = k - 1; d = out_data;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("out_valid bound", 0, 1);
   endtask

   initial begin : watchdog
      #2000000;
      n_err++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin : main
      logic [63:0] d, d0;
      int lat;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #4;
      chk("idle cfg_ready", cfg_ready, 1);
      chk("idle in_ready", in_ready, 0);

      // ECB-enc latency and value
      do_cfg(2'd0, {64'h0, 64'h1}, 64'h0);
      send(64'h10);
      wait_out(d, lat);
      chk("ecb_enc data", d, 64'h11);
      chk("ecb_enc latency", lat, 27);
      chk("ecb_enc blk_count", blk_count, 1);

      // CBC-enc chaining
      do_cfg(2'd2, 128'h0, 64'hF0);
      send(64'h0F); wait_out(d, lat); chk("cbc_enc first", d, 64'hFF);
      send(64'h0F); wait_out(d, lat); chk("cbc_enc second", d, 64'hF0);

      // CBC-dec chaining
      do_cfg(2'd3, 128'h0, 64'hF0);
      send(64'hFF); wait_out(d, lat); chk("cbc_dec first", d, 64'h0F);
      send(64'hF0); wait_out(d, lat); chk("cbc_dec second", d, 64'h0F);
      chk("cbc_dec blk_count", blk_count, 2);

      // Backpressure
      or_mode = 0;
      do_cfg(2'd0, {64'h0, 64'h5}, 64'h0);
      send(64'h1); wait_out(d0, lat);
      chk("bp first", d0, 64'h4);
      @(negedge clk);
      in_valid = 1'b1; in_data = 64'h2;
      for (int i = 0; i < 100; i++) begin
         #4;
         chk("bp in_ready", in_ready, 0);
         chk("bp out_data", out_data, 64'h4);
         chk("bp core_enable", core_enable, 0);
         @(negedge clk);
      end
      or_mode = 1;
      send(64'h2); wait_out(d, lat); chk("bp second", d, 64'h7);

      // Timeout
      stub_mute = 1'b1;
      do_cfg(2'd0, {64'h0, 64'h9}, 64'h0);
      send(64'h3);
      lat = -1;
      for (int k = 1; k <= T + 50; k++) begin
         #4;
         if (err) begin lat = k - 1; break; end
         @(negedge clk);
      end
      chk("timeout cycles", lat, T);
      stub_mute = 1'b0;
      do_cfg(2'd0, {64'h0, 64'h9}, 64'h0);
      #4; chk("err cleared", err, 0);
      send(64'h4); wait_out(d, lat); chk("after err data", d, 64'hD);

      // Reset mid-BUSY
      do_cfg(2'd2, {64'hA5, 64'h3C}, 64'h77);
      send(64'h1234);
      repeat (9) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("amid core_enable", core_enable, 0);
      chk("amid core_encrypt", core_encrypt, 0);
      chk("amid out_valid", out_valid, 0);
      chk("amid in_ready", in_ready, 0);
      chk("amid blk_count", blk_count, 0);
      chk("amid text/key", {core_text_in, core_key0}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         #4; chk("no stale out_valid", out_valid, 0);
         @(negedge clk);
      end

      // Randomized traffic
      do_cfg(2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
      or_mode = 2;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = {$urandom, $urandom};
         cfg_start = ($urandom_range(0, 59) == 0);
         if (cfg_start) begin
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_key  = {$urandom, $urandom, $urandom, $urandom};
            cfg_iv   = {$urandom, $urandom};
         end
      end
      @(negedge clk);
      in_valid = 1'b0; cfg_start = 1'b0; or_mode = 1;
      repeat (40) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
